// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and flag bit positions shared by alu_seq and the branch unit.
package alu_pkg;
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_PASSB = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_MUL   = 4'd9;
    typedef enum logic {ALU_S_IDLE, ALU_S_MUL} alu_state_e;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    typedef logic [3:0] alu_flags_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: valid/ready operation channel in, valid/ready result+flags channel out.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zf;
    logic             nf;
    logic             cf;
    logic             vf;
    modport master (
        output in_valid, alu_op, a, b, out_ready,
        input  in_ready, out_valid, y, zf, nf, cf, vf
    );
    modport slave (
        input  in_valid, alu_op, a, b, out_ready,
        output in_ready, out_valid, y, zf, nf, cf, vf
    );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add unsigned multiplier, one multiplier bit per cycle, WIDTH steps.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter #(parameter int WIDTH = 32) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH:0]     sum;
    logic               step;
    assign done    = busy_q && cnt_q == '0;
    assign product = p_q;
    assign step    = busy_q && cnt_q != '0;
    // p holds {partial sum, remaining multiplier bits}; each step adds a and shifts right
    always_comb begin
        sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a_q : {WIDTH{1'b0}})};
        busy_d = start ? 1'b1 : busy_q && !done;
        cnt_d  = start ? CW'(WIDTH) : step ? cnt_q - CW'(1) : cnt_q;
        a_d    = start ? a : a_q;
        p_d    = start ? {{WIDTH{1'b0}}, b} : step ? {sum, p_q[WIDTH-1:1]} : p_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            p_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            p_q    <= p_d;
        end
    end
endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and Z/N/C/V flags.
// ALU_MUL_EN enables the iterative multiplier (opcode 9); otherwise opcode 9 is illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    alu_state_e         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   y_q, y_d, res;
    alu_flags_t         flags_q, flags_d, res_flags;
    logic               accept, is_mul, mul_start, mul_done, load, c, v;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     add_w, sub_w;
    logic [SHW-1:0]     sh;
    assign bus.in_ready = !rst && state_q == ALU_S_IDLE && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_start    = accept && is_mul;
    assign load         = (accept && !is_mul) || mul_done;
`ifdef ALU_MUL_EN
    assign is_mul = bus.alu_op == ALU_MUL;
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (prod)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign prod     = '0;
`endif
    always_comb begin
        add_w = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        sh    = bus.b[SHW-1:0];
        res   = '0;
        c     = 1'b0;
        v     = 1'b0;
        if (mul_done) begin
            res = prod[WIDTH-1:0];
            v   = |prod[2*WIDTH-1:WIDTH];
        end else begin
            case (bus.alu_op)
                ALU_ADD: begin
                    res = add_w[WIDTH-1:0];
                    c   = add_w[WIDTH];
                    v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (res[WIDTH-1] != bus.a[WIDTH-1]);
                end
                ALU_SUB: begin
                    res = sub_w[WIDTH-1:0];
                    c   = !sub_w[WIDTH];
                    v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (res[WIDTH-1] != bus.a[WIDTH-1]);
                end
                ALU_AND:   res = bus.a & bus.b;
                ALU_OR:    res = bus.a | bus.b;
                ALU_XOR:   res = bus.a ^ bus.b;
                ALU_PASSB: res = bus.b;
                ALU_SLL:   res = bus.a << sh;
                ALU_SRL:   res = bus.a >> sh;
                ALU_SRA:   res = $signed(bus.a) >>> sh;
                default:   res = '0;
            endcase
        end
        res_flags         = '0;
        res_flags[FLAG_Z] = res == '0;
        res_flags[FLAG_N] = res[WIDTH-1];
        res_flags[FLAG_C] = c;
        res_flags[FLAG_V] = v;
    end
    // reloading on the same edge as a drain keeps out_valid high with no bubble
    always_comb begin
        state_d     = mul_start ? ALU_S_MUL : mul_done ? ALU_S_IDLE : state_q;
        out_valid_d = load || (out_valid_q && !bus.out_ready);
        y_d         = load ? res : y_q;
        flags_d     = load ? res_flags : flags_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ALU_S_IDLE;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
        end
    end
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zf        = flags_q[FLAG_Z];
    assign bus.nf        = flags_q[FLAG_N];
    assign bus.cf        = flags_q[FLAG_C];
    assign bus.vf        = flags_q[FLAG_V];
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an arithmetic reference model.
// MUL scenarios are exercised when ALU_MUL_EN is defined; otherwise opcode 9 is checked as illegal.
module tb_alu_seq;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    alu_seq_if #(.WIDTH(W)) bus();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // expected {y, zf, nf, cf, vf} from plain integer arithmetic
    function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        logic [63:0] w;
        logic [W-1:0] r, ones;
        logic c, v;
        int sh;
        sh = int'(b[4:0]);
        ones = '1;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                w = 64'(a) + 64'(b);
                r = w[31:0];
                c = w[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = s != longint'($signed(r));
            end
            4'd1: begin
                r = a - b;
                c = a < b;
                s = longint'($signed(a)) - longint'($signed(b));
                v = s != longint'($signed(r));
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = b;
            4'd6: r = a << sh;
            4'd7: r = a >> sh;
            4'd8: r = (a >> sh) | (a[31] ? ~(ones >> sh) : '0);
`ifdef ALU_MUL_EN
            4'd9: begin
                w = 64'(a) * 64'(b);
                r = w[31:0];
                v = w[63:32] != 0;
            end
`endif
            default: r = '0;
        endcase
        return {r, r == '0, r[31], c, v};
    endfunction

    function automatic logic [W+3:0] observed();
        return {bus.y, bus.zf, bus.nf, bus.cf, bus.vf};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.alu_op = op;
        bus.a = a;
        bus.b = b;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        issue(4'd0, 32'd1, 32'd1);
        repeat (3) step();
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        tests++;
        if (observed() !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", observed()); end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [3:0] ops [3] = '{4'd0, 4'd1, 4'd8};
        logic [W-1:0] as [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] bs [3] = '{32'd1, 32'd1, 32'd4};
        logic [W+3:0] exp [3] = '{{32'h0, 4'b1010}, {32'h7FFF_FFFF, 4'b0001}, {32'hF800_0000, 4'b0100}};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            step();
            tests++;
            if (bus.out_valid !== 1'b1 || observed() !== exp[i]) begin
                fails++;
                $display("FAIL directed_%0d: got valid=%b %h expected valid=1 %h", i, bus.out_valid, observed(), exp[i]);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3] = '{4'd0, 4'd4, 4'd6};
        logic [W-1:0] a, b;
        logic [W+3:0] exp;
        for (int i = 0; i < 3; i++) begin
            a = $urandom();
            b = $urandom();
            exp = model(ops[i], a, b);
            issue(ops[i], a, b);
            tests++;
            if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.in_ready); end
            step();
            tests++;
            if (bus.out_valid !== 1'b1 || observed() !== exp) begin
                fails++;
                $display("FAIL b2b_result_%0d: got valid=%b %h expected valid=1 %h", i, bus.out_valid, observed(), exp);
            end
        end
        drain();
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [W-1:0] a, b;
        logic [W+3:0] exp;
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.in_valid = 1'b0;
                step();
                tests++;
                if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rand_idle_%0d: got out_valid=%b expected 0", i, bus.out_valid); end
                continue;
            end
            op = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
            if (op == 4'd9) op = 4'd0;
`endif
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            exp = model(op, a, b);
            issue(op, a, b);
            if (bus.in_ready !== 1'b1) bad++;
            step();
            tests++;
            if (bus.out_valid !== 1'b1 || observed() !== exp) begin
                fails++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: got valid=%b %h expected valid=1 %h", i, op, a, b, bus.out_valid, observed(), exp);
            end
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL rand_in_ready: got %0d stalled cycles expected 0", bad); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [W+3:0] exp1, exp2;
        int bad = 0;
        drain();
        bus.out_ready = 1'b0;
        exp1 = model(4'd0, 32'h1234_5678, 32'h0FED_CBA9);
        issue(4'd0, 32'h1234_5678, 32'h0FED_CBA9);
        step();
        exp2 = model(4'd4, 32'hDEAD_BEEF, 32'hFFFF_0000);
        issue(4'd4, 32'hDEAD_BEEF, 32'hFFFF_0000);
        for (int i = 0; i < 5; i++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || observed() !== exp1) bad++;
            step();
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
        tests++;
        if (observed() !== exp1) begin fails++; $display("FAIL bp_held_value: got %h expected %h", observed(), exp1); end
        bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        step();
        tests++;
        if (bus.out_valid !== 1'b1 || observed() !== exp2) begin
            fails++;
            $display("FAIL bp_reload: got valid=%b %h expected valid=1 %h", bus.out_valid, observed(), exp2);
        end
        drain();
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        logic [W-1:0] a, b;
        logic [W+3:0] exp;
        int lat, bad;
        for (int k = 0; k < 6; k++) begin
            a = (k == 0) ? 32'h0001_0000 : (k == 1) ? 32'd7 : $urandom();
            b = (k == 0) ? 32'h0001_0000 : (k == 1) ? 32'd6 : (k == 2) ? 32'($urandom_range(0, 65535)) : $urandom();
            exp = (k == 0) ? {32'h0, 4'b1001} : (k == 1) ? {32'd42, 4'b0000} : model(4'd9, a, b);
            drain();
            issue(4'd9, a, b);
            step();
            issue(4'd0, 32'd1, 32'd1);
            lat = 0;
            bad = 0;
            for (int n = 1; n <= 40; n++) begin
                step();
                if (bus.out_valid === 1'b1) begin lat = n; break; end
                if (bus.in_ready !== 1'b0) bad++;
            end
            tests++;
            if (lat != W + 1) begin fails++; $display("FAIL mul_latency_%0d: got %0d expected %0d", k, lat, W + 1); end
            tests++;
            if (bad != 0) begin fails++; $display("FAIL mul_in_ready_%0d: got %0d ready cycles expected 0", k, bad); end
            tests++;
            if (observed() !== exp) begin fails++; $display("FAIL mul_result_%0d: got %h expected %h", k, observed(), exp); end
            bus.in_valid = 1'b0;
        end
        drain();
    endtask
`else
    task automatic test_illegal_mul();
        drain();
        issue(4'd9, $urandom(), $urandom());
        step();
        tests++;
        if (bus.out_valid !== 1'b1 || observed() !== {32'h0, 4'b1000}) begin
            fails++;
            $display("FAIL op9_illegal: got valid=%b %h expected valid=1 %h", bus.out_valid, observed(), {32'h0, 4'b1000});
        end
        drain();
    endtask
`endif

    task automatic test_reset_midop();
        int seen = 0;
        drain();
`ifdef ALU_MUL_EN
        issue(4'd9, 32'd3, 32'd5);
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
`else
        bus.out_ready = 1'b0;
        issue(4'd0, 32'd2, 32'd2);
        step();
        bus.in_valid = 1'b0;
`endif
        rst = 1'b1;
        step();
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midop_reset: got in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midop_release_ready: got %b expected 1", bus.in_ready); end
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.out_valid !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL midop_no_output: got %0d valid cycles expected 0", seen); end
        issue(4'd0, 32'd2, 32'd3);
        step();
        tests++;
        if (bus.out_valid !== 1'b1 || observed() !== {32'd5, 4'b0000}) begin
            fails++;
            $display("FAIL midop_add: got valid=%b %h expected valid=1 %h", bus.out_valid, observed(), {32'd5, 4'b0000});
        end
        drain();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.alu_op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_backpressure();
`ifdef ALU_MUL_EN
        test_mul();
`else
        test_illegal_mul();
`endif
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational datapath ALU. Accepts one operation per cycle on a valid/ready input channel and returns a registered result plus condition flags (Z/N/C/V) on a valid/ready output channel. Adds shifts and an optional iterative multiplier that takes WIDTH cycles. Sits between the decode/operand-fetch stage and writeback, so the pipeline can stall on multi-cycle operations.

## Interface
- WIDTH, 32, datapath width in bits; must be at least 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept this cycle
- alu_op  in  4  opcode: 0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=PASSB 6=SLL 7=SRL 8=SRA 9=MUL; others are illegal
- a, b  in  WIDTH  operands
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- y  out  WIDTH  result
- zf, nf, cf, vf  out  1 each  zero, negative (y[WIDTH-1]), carry, overflow

## Operation
- States: IDLE, MUL.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready).
- An operation is accepted when in_valid && in_ready.
- Single-cycle ops (0–8, illegal): result and flags are registered on the accept edge, and out_valid=1 next cycle. State stays IDLE, so back-to-back throughput is 1 per cycle.
- MUL is accepted in IDLE and moves to MUL.
  - Operands are latched and the counter is loaded with WIDTH.
  - Shift-add runs 1 bit per cycle.
  - When the counter reaches 0, y = low WIDTH bits of the unsigned product, out_valid=1, and state returns to IDLE.
- Output register: holds y and flags while out_valid && !out_ready. It clears out_valid on out_ready unless it is reloaded in the same cycle.
- Arithmetic:
  - ADD: cf = carry out.
  - SUB: y = a + ~b + 1; cf = borrow (a < b unsigned).
  - ADD/SUB vf = signed overflow.
  - Shifts: amount = b[SHW-1:0]. SRA replicates a[WIDTH-1]. cf = vf = 0.
  - Logic and PASSB: cf = vf = 0.
  - MUL: cf = 0; vf = 1 iff the high WIDTH bits of the product are nonzero.
  - Illegal op: y = 0, zf = 1, other flags 0.
- zf = (y==0) and nf = y[WIDTH-1] for every op.

## Timing
- Reset values: out_valid=0, y=0, zf=nf=cf=vf=0, state IDLE, counter 0, in_ready=0 while rst=1.
- Latency from accept to out_valid:
  - single-cycle ops: 1 cycle
  - MUL: WIDTH+1 cycles
- in_ready is low for the entire MUL state.
- Simultaneous drain and accept (out_valid && out_ready && in_valid, IDLE): the new result is loaded and out_valid stays 1. There is no bubble.
- Backpressure: if out_ready=0, in_ready=0; the held result does not change.
- MUL completion: the output register is guaranteed empty, so completion never stalls.
- rst mid-MUL: the operation is aborted with no output; the next cycle after rst deasserts is IDLE.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready.

## Configuration
- ALU_MUL_EN defined: the iterative multiplier is instantiated; MUL behaves as above.
- ALU_MUL_EN undefined: the MUL state and multiplier are removed. Opcode 9 is treated as illegal: single-cycle, y=0, zf=1.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams: ALU_ADD … ALU_MUL
  - state enum: ALU_S_IDLE, ALU_S_MUL
  - flag bit ordering, shared with the branch unit
- One sub-module, alu_mul_iter (WIDTH):
  - inputs: start, a, b
  - outputs: done, 2*WIDTH-bit product
  - holds the counter and shift-add accumulator; compiled only under ALU_MUL_EN.
- Top level holds the handshake, single-cycle datapath, flags and output register.

## Test plan
- Reset, then ADD a=32'hFFFF_FFFF b=1 with out_ready=1 → next cycle out_valid=1, y=0, zf=1, cf=1, vf=0.
- SUB a=32'h8000_0000 b=1 → y=32'h7FFF_FFFF, vf=1, cf=0, nf=0; then SRA a=32'h8000_0000 b=4 → y=32'hF800_0000, nf=1.
- Stream ADD, XOR, SLL on consecutive cycles with out_ready=1 → three results on consecutive cycles; in_ready stays 1.
- Hold out_ready=0 after one ADD → in_ready=0 and y is held for 5 cycles; raise out_ready with in_valid=1 → new result next cycle, no gap.
- ALU_MUL_EN, MUL 32'h0001_0000 × 32'h0001_0000 → in_ready low for 32 cycles, out_valid at accept+33, y=0, vf=1, zf=1; 7×6 → y=42, vf=0.
- Assert rst 10 cycles into a MUL → no out_valid; after release in_ready=1 and a following ADD 2+3 → y=5.
